noise_bit_receiver: RTL and testbench

- Receive-side counterpart of the background noise/interference transmitter.
- Observes a single sensed activity line, such as a ring-oscillator or timing-sensor output that is disturbed by the transmitter's toggling registers.
- Counts toggles per fixed bit window, slices each window to a bit against a threshold, hunts for a preamble byte, then assembles framed payload bytes.
- Payload bytes are delivered over a one-entry valid/ready buffer to downstream logging logic.

---
 rtl/noise_bit_receiver.sv | 160 ++++++++++++++++
 tb/tb_noise_bit_receiver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/noise_bit_receiver.sv
// Receive side of the noise channel: counts toggles on a sensed activity line per
// window, slices each window to a bit, hunts for a preamble and frames payload bytes.
module noise_bit_receiver #(
   parameter int         WINDOW      = 256,
   parameter int         CNT_W       = 9,
   parameter int         THRESH      = 128,
   parameter logic [7:0] PREAMBLE    = 8'hA5,
   parameter int         FRAME_BYTES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       sense_in,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       locked,
   output logic       overrun,
   output logic       bit_out,
   output logic       bit_strobe
);
   // state | meaning
   // IDLE  | receiver stopped; window, toggle and shift state held at zero
   // HUNT  | slicing bits and searching the shift register for PREAMBLE
   // DATA  | assembling FRAME_BYTES payload bytes, MSB first
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HUNT = 2'd1,
      S_DATA = 2'd2
   } state_t;

   localparam int              WC_W      = $clog2(WINDOW);
   localparam int              BC_W      = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam logic [WC_W-1:0] WIN_LAST  = WC_W'(WINDOW - 1);
   localparam logic [BC_W-1:0] BYTE_LAST = BC_W'(FRAME_BYTES - 1);
   localparam logic [CNT_W:0]  THRESH_X  = (CNT_W + 1)'(THRESH);
   localparam logic [CNT_W-1:0] TCNT_MAX = '1;

   state_t            state_q, state_d;
   logic              sync1, sync2, prev;
   logic              toggle;
   logic [WC_W-1:0]   wcnt;
   logic [CNT_W-1:0]  tcnt;
   logic [CNT_W:0]    tsum;
   logic              bit_dec;
   logic              run;
   logic              win_end;
   logic [7:0]        sh, sh_next;
   logic [2:0]        bitcnt;
   logic [BC_W-1:0]   bytecnt;
   logic              byte_done, frame_done;
   logic              load_pend;
   logic [7:0]        byte_pend;

   assign toggle  = sync2 ^ prev;
   assign run     = enable && (state_q != S_IDLE);
   assign win_end = run && (wcnt == WIN_LAST);
   // the toggle seen on the window-end cycle still belongs to the ending window
   assign tsum    = {1'b0, tcnt} + {{CNT_W{1'b0}}, toggle};
   assign bit_dec = (tsum >= THRESH_X);
   assign sh_next = {sh[6:0], bit_dec};

   always_comb begin
      state_d    = state_q;
      byte_done  = 1'b0;
      frame_done = 1'b0;
      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_HUNT;
            S_HUNT: begin
               if (win_end && (sh_next == PREAMBLE)) state_d = S_DATA;
            end
            S_DATA: begin
               if (win_end && (bitcnt == 3'd7)) begin
                  byte_done = 1'b1;
                  if (bytecnt == BYTE_LAST) begin
                     frame_done = 1'b1;
                     state_d    = S_HUNT;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         prev       <= 1'b0;
         wcnt       <= '0;
         tcnt       <= '0;
         sh         <= 8'h00;
         bitcnt     <= 3'd0;
         bytecnt    <= '0;
         bit_out    <= 1'b0;
         bit_strobe <= 1'b0;
         locked     <= 1'b0;
         load_pend  <= 1'b0;
         byte_pend  <= 8'h00;
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         sync1      <= sense_in;
         sync2      <= sync1;
         prev       <= sync2;
         bit_strobe <= 1'b0;
         load_pend  <= byte_done;
         locked     <= (state_d == S_DATA);

         if (!run) begin
            wcnt    <= '0;
            tcnt    <= '0;
            sh      <= 8'h00;
            bitcnt  <= 3'd0;
            bytecnt <= '0;
         end else if (win_end) begin
            wcnt       <= '0;
            tcnt       <= '0;
            bit_out    <= bit_dec;
            bit_strobe <= 1'b1;
            sh         <= frame_done ? 8'h00 : sh_next;
            if (state_q == S_DATA) begin
               bitcnt <= bitcnt + 3'd1;
               if (byte_done) bytecnt <= frame_done ? '0 : bytecnt + BC_W'(1);
            end else begin
               bitcnt  <= 3'd0;
               bytecnt <= '0;
            end
         end else begin
            wcnt <= wcnt + WC_W'(1);
            if (toggle && (tcnt != TCNT_MAX)) tcnt <= tcnt + CNT_W'(1);
         end

         if (byte_done) byte_pend <= sh_next;

         // a byte arriving while the buffer is still occupied is lost, not queued
         if (load_pend) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= byte_pend;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_noise_bit_receiver.sv
// Directed bench for noise_bit_receiver: windows are streamed back to back so the
// sensed line stays aligned with the receiver's bit windows.
module tb_noise_bit_receiver;
   logic       clk      = 1'b0;
   logic       rst      = 1'b0;
   logic       enable   = 1'b0;
   logic       sense_in = 1'b0;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, locked, overrun, bit_out, bit_strobe;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         strobe_cnt, strobe_pos;
   logic       last_bit, lk0, lk1, first_lk0, first_lk1;
   logic [7:0] got_q[$];

   noise_bit_receiver #(
      .WINDOW(16), .CNT_W(5), .THRESH(8), .PREAMBLE(8'hA5), .FRAME_BYTES(2)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .sense_in(sense_in), .rx_ready(rx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .locked(locked), .overrun(overrun),
      .bit_out(bit_out), .bit_strobe(bit_strobe)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One bit window: ntog toggles at its start; rx_ready pulses high for one edge when rdy_pulse >= 0.
   task automatic send_win(input int ntog, input int rdy_pulse);
      strobe_cnt = 0;
      strobe_pos = -1;
      for (int t = 0; t < 16; t++) begin
         if (t < ntog) sense_in = ~sense_in;
         if (t == rdy_pulse) rx_ready = 1'b1;
         else if (rdy_pulse >= 0 && t == rdy_pulse + 1) rx_ready = 1'b0;
         if (rx_valid && rx_ready) got_q.push_back(rx_data);
         tick();
         if (bit_strobe) begin
            strobe_cnt++;
            strobe_pos = t;
            last_bit   = bit_out;
         end
         if (t == 0) lk0 = locked;
         if (t == 1) lk1 = locked;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         send_win(b[i] ? 16 : 0, -1);
         if (i == 7) begin
            first_lk0 = lk0;
            first_lk1 = lk1;
         end
      end
   endtask

   task automatic start_rx();
      enable = 1'b1;
      repeat (15) tick();
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      enable   = 1'b0;
      rx_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      int cnt;
      rst = 1'b0; enable = 1'b0; rx_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sense_in = ~sense_in;
         tick();
      end
      n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      n_checks++; if (bit_out !== 1'b0) begin n_fail++; $display("FAIL reset_bit_out: got %b want 0", bit_out); end
      n_checks++; if (bit_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_bit_strobe: got %b want 0", bit_strobe); end
      rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         sense_in = ~sense_in;
         tick();
         if (bit_strobe) cnt++;
      end
      n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL disabled_strobes: got %0d want 0", cnt); end
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL disabled_locked: got %b want 0", locked); end
      repeat (3) tick();
   endtask

   task automatic test_slicing();
      start_rx();
      send_win(7, -1);
      send_win(8, -1);
      n_checks++; if (strobe_cnt !== 1) begin n_fail++; $display("FAIL slice7_strobe_count: got %0d want 1", strobe_cnt); end
      n_checks++; if (strobe_pos !== 1) begin n_fail++; $display("FAIL slice7_strobe_pos: got %0d want 1", strobe_pos); end
      n_checks++; if (last_bit !== 1'b0) begin n_fail++; $display("FAIL slice7_bit: got %b want 0", last_bit); end
      send_win(0, -1);
      n_checks++; if (strobe_cnt !== 1) begin n_fail++; $display("FAIL slice8_strobe_count: got %0d want 1", strobe_cnt); end
      n_checks++; if (strobe_pos !== 1) begin n_fail++; $display("FAIL slice8_strobe_pos: got %0d want 1", strobe_pos); end
      n_checks++; if (last_bit !== 1'b1) begin n_fail++; $display("FAIL slice8_bit: got %b want 1", last_bit); end
   endtask

   task automatic test_frame();
      logic [7:0] g0, g1;
      rx_ready = 1'b1;
      got_q.delete();
      send_byte(8'h00);
      send_byte(8'hA5);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL frame_unlocked_before_end: got %b want 0", locked); end
      send_byte(8'h3C);
      n_checks++; if (first_lk0 !== 1'b0) begin n_fail++; $display("FAIL frame_lock_early: got %b want 0", first_lk0); end
      n_checks++; if (first_lk1 !== 1'b1) begin n_fail++; $display("FAIL frame_lock_rise: got %b want 1", first_lk1); end
      n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL frame_no_preamble_out: got %0d bytes want 0", got_q.size()); end
      send_byte(8'hC3);
      send_win(0, -1);
      n_checks++; if (lk0 !== 1'b1 || lk1 !== 1'b0) begin n_fail++; $display("FAIL frame_lock_fall: got %b%b want 10", lk0, lk1); end
      n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL frame_byte_count: got %0d want 2", got_q.size()); end
      g0 = (got_q.size() > 0) ? got_q[0] : 8'hxx;
      g1 = (got_q.size() > 1) ? got_q[1] : 8'hxx;
      n_checks++; if (g0 !== 8'h3C) begin n_fail++; $display("FAIL frame_byte0: got %h want 3c", g0); end
      n_checks++; if (g1 !== 8'hC3) begin n_fail++; $display("FAIL frame_byte1: got %h want c3", g1); end
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL frame_drained: got %b want 0", rx_valid); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL frame_overrun: got %b want 0", overrun); end
   endtask

   task automatic test_backpressure();
      logic [7:0] g0;
      got_q.delete();
      rx_ready = 1'b0;
      send_byte(8'hA5);
      send_byte(8'h3C);
      send_byte(8'hC3);
      send_win(0, -1);
      n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL bp_no_handshake: got %0d want 0", got_q.size()); end
      n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b want 1", rx_valid); end
      n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL bp_data_held: got %h want 3c", rx_data); end
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun: got %b want 1", overrun); end
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL bp_unlocked: got %b want 0", locked); end
      rx_ready = 1'b1;
      send_win(0, -1);
      g0 = (got_q.size() > 0) ? got_q[0] : 8'hxx;
      n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL bp_one_handshake: got %0d want 1", got_q.size()); end
      n_checks++; if (g0 !== 8'h3C) begin n_fail++; $display("FAIL bp_drain_byte: got %h want 3c", g0); end
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_clear: got %b want 0", rx_valid); end
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun_sticky: got %b want 1", overrun); end
   endtask

   task automatic test_simultaneous();
      logic [7:0] g0;
      do_reset();
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL sim_overrun_reset: got %b want 0", overrun); end
      start_rx();
      got_q.delete();
      rx_ready = 1'b0;
      send_byte(8'hA5);
      send_byte(8'h3C);
      send_byte(8'hC3);
      send_win(0, 2);
      g0 = (got_q.size() > 0) ? got_q[0] : 8'hxx;
      n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL sim_handshakes: got %0d want 1", got_q.size()); end
      n_checks++; if (g0 !== 8'h3C) begin n_fail++; $display("FAIL sim_consumed: got %h want 3c", g0); end
      n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin n_fail++; $display("FAIL sim_loaded: got valid=%b data=%h want valid=1 data=c3", rx_valid, rx_data); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL sim_no_overrun: got %b want 0", overrun); end
      rst = 1'b0;
      #2;
      n_checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin n_fail++; $display("FAIL async_reset_buffer: got valid=%b data=%h want valid=0 data=00", rx_valid, rx_data); end
      tick();
      rst = 1'b1;
      enable = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      int cnt;
      logic [7:0] g0, g1;
      rx_ready = 1'b1;
      got_q.delete();
      start_rx();
      send_byte(8'hA5);
      send_win(16, -1);
      send_win(0, -1);
      send_win(16, -1);
      send_win(16, -1);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL abort_locked_before: got %b want 1", locked); end
      enable = 1'b0;
      tick();
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL abort_locked_after: got %b want 0", locked); end
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bit_strobe) cnt++;
      end
      n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL abort_idle_strobes: got %0d want 0", cnt); end
      start_rx();
      send_byte(8'hA5);
      send_byte(8'h3C);
      send_byte(8'hC3);
      send_win(0, -1);
      g0 = (got_q.size() > 0) ? got_q[0] : 8'hxx;
      g1 = (got_q.size() > 1) ? got_q[1] : 8'hxx;
      n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL abort_byte_count: got %0d want 2", got_q.size()); end
      n_checks++; if (g0 !== 8'h3C) begin n_fail++; $display("FAIL abort_byte0: got %h want 3c", g0); end
      n_checks++; if (g1 !== 8'hC3) begin n_fail++; $display("FAIL abort_byte1: got %h want c3", g1); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL abort_overrun: got %b want 0", overrun); end
   endtask

   initial begin
      test_reset();
      test_slicing();
      test_frame();
      test_backpressure();
      test_simultaneous();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
